// File: rtl/scope_pkg.sv
// Shared constants and state encoding for the oscilloscope frame-buffer arbiter.
package scope_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int COORD_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } fb_state_t;

  // Graticule: every 64th column/line plus the right and bottom borders.
  function automatic logic on_graticule(
    input logic [COORD_W-1:0] col,
    input logic [COORD_W-1:0] row,
    input logic [COORD_W-1:0] col_last,
    input logic [COORD_W-1:0] row_last
  );
    return (col[5:0] == 6'd0) || (row[5:0] == 6'd0) ||
           (col == col_last) || (row == row_last);
  endfunction

endpackage

// File: rtl/scope_pix_gen.sv
// Two-stage pixel pipeline: aligns x/y with trace-RAM read data, then decides trace and grid pixels.
module scope_pix_gen #(
  parameter int H_ACTIVE = scope_pkg::H_ACTIVE,
  parameter int V_ACTIVE = scope_pkg::V_ACTIVE,
  parameter int DATA_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              trace_on,
  output logic              grid_on
);
  import scope_pkg::on_graticule;

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  logic       active_p1;
  logic [9:0] x_p1;
  logic [9:0] y_p1;
  logic [9:0] rdata_ext;
  logic       trace_hit_p1;
  logic       grid_hit_p1;

  assign rdata_ext    = 10'(mem_rdata);
  assign trace_hit_p1 = active_p1 && (rdata_ext == y_p1);
  assign grid_hit_p1  = active_p1 && on_graticule(x_p1, y_p1, X_LAST, Y_LAST);

  // stage 1: coordinates registered alongside the RAM read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_p1 <= 1'b0;
      x_p1      <= '0;
      y_p1      <= '0;
    end else begin
      active_p1 <= active;
      x_p1      <= x;
      y_p1      <= y;
    end
  end

  // stage 2: registered pixel decisions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trace_on <= 1'b0;
      grid_on  <= 1'b0;
    end else begin
      trace_on <= trace_hit_p1;
      grid_on  <= grid_hit_p1;
    end
  end

endmodule

// File: rtl/scope_fb_arbiter.sv
// Shares one single-port trace RAM between the VGA scan-out (absolute priority) and the capture writer.
module scope_fb_arbiter #(
  parameter int H_ACTIVE = scope_pkg::H_ACTIVE,
  parameter int V_ACTIVE = scope_pkg::V_ACTIVE,
  parameter int DATA_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              arm,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              full,
  output logic [9:0]        mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              trace_on,
  output logic              grid_on
);
  import scope_pkg::fb_state_t;
  import scope_pkg::ST_IDLE;
  import scope_pkg::ST_FILL;
  import scope_pkg::ST_FULL;

  localparam logic [9:0] H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM    = 10'(V_ACTIVE);
  localparam logic [9:0] PTR_LAST = 10'(H_ACTIVE - 1);

  fb_state_t  state;
  logic [9:0] wr_ptr;
  logic       full_q;
  logic       active;
  logic       grant;

  assign active = (x < H_LIM) && (y < V_LIM);

  // A write only slips into blanking, and never in the cycle an arm restarts the capture.
  always_comb begin
    grant = 1'b0;
    if (rst_n && (state == ST_FILL) && wr_req && !active && !arm) begin
      grant = 1'b1;
    end
  end

  assign wr_ack    = grant;
  assign mem_we    = grant;
  assign mem_addr  = active ? x : wr_ptr;
  assign mem_wdata = wr_data;
  assign full      = full_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      full_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state  <= ST_FILL;
            wr_ptr <= '0;
          end
        end
        ST_FILL: begin
          if (arm) begin
            wr_ptr <= '0;
          end else if (grant) begin
            if (wr_ptr == PTR_LAST) begin
              state  <= ST_FULL;
              wr_ptr <= '0;
              full_q <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 10'd1;
            end
          end
        end
        ST_FULL: begin
          if (arm) begin
            state  <= ST_FILL;
            wr_ptr <= '0;
            full_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          wr_ptr <= '0;
          full_q <= 1'b0;
        end
      endcase
    end
  end

  scope_pix_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .DATA_W   (DATA_W)
  ) u_pix_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (active),
    .x         (x),
    .y         (y),
    .mem_rdata (mem_rdata),
    .trace_on  (trace_on),
    .grid_on   (grid_on)
  );

endmodule
